bus_responder: RTL and testbench

Byte-wide memory-mapped responder at the far end of the CPU bus. It answers the CPU's `read` / `address` / `dout` / `din` transactions with a on-chip RAM and a small I/O page. The I/O page holds a 4-entry transmit FIFO with a valid/ready output and a 16-bit compare timer. It sits between the CPU and downstream byte consumers, for example a UART or debug port.

---
 rtl/bus_responder_if.sv | 19 +
 rtl/bus_responder.sv | 93 +++++++++
 tb/tb_bus_responder.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/bus_responder_if.sv
// bus_responder_if: CPU byte bus plus transmit stream and interrupt of bus_responder
interface bus_responder_if;
  logic        read;
  logic [15:0] address;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        irq;
  modport master (
    output read, address, wdata, tx_ready,
    input  rdata, tx_data, tx_valid, irq
  );
  modport slave (
    input  read, address, wdata, tx_ready,
    output rdata, tx_data, tx_valid, irq
  );
endinterface

// File: rtl/bus_responder.sv
// bus_responder: byte RAM + I/O page (4-deep TX FIFO, compare timer under BUS_RESPONDER_TIMER_EN)
module bus_responder #(
  parameter int AW = 12
) (
  input logic             clk,
  input logic             rst,
  bus_responder_if.slave  bus
);
  logic [7:0] ram [0:(1<<AW)-1];
  logic [7:0] fifo [0:3];
  logic [1:0] rd_ptr, wr_ptr;
  logic [2:0] count;
  logic [7:0] rdata, rd_val, status, off;
  logic [7:0] t_lo, t_hi, c_lo, c_hi;
  logic       is_ram, is_io, full, empty, push, pop, flag;
  assign is_ram = bus.address[15:AW] == '0;
  assign is_io  = bus.address[15:8] == 8'hFF;
  assign off    = bus.address[7:0];
  assign full   = count == 3'd4;
  assign empty  = count == 3'd0;
  assign push   = !bus.read && is_io && off == 8'h00 && !full;
  assign pop    = !empty && bus.tx_ready;
  assign status = {5'd0, flag, empty, full};
  // RAM is not reset; writes are held off while reset is asserted
  always_ff @(posedge clk)
    if (rst && !bus.read && is_ram) ram[bus.address[AW-1:0]] <= bus.wdata;
  // FIFO storage carries no reset; only the pointers and count define its contents
  always_ff @(posedge clk)
    if (rst && push) fifo[wr_ptr] <= bus.wdata;
  // FIFO pointers and occupancy; a push while full was already rejected above
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rd_ptr <= 2'd0;
      wr_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'd0, push} - {2'd0, pop};
    end
`ifdef BUS_RESPONDER_TIMER_EN
  logic [15:0] cnt, cmp;
  logic [7:0]  hi_lat;
  // free-running counter, compare flag (set beats clear) and TIMER_HI snapshot on TIMER_LO reads
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt    <= 16'h0000;
      cmp    <= 16'hFFFF;
      hi_lat <= 8'h00;
      flag   <= 1'b0;
    end else begin
      cnt <= cnt + 16'd1;
      if (bus.read && is_io && off == 8'h02) hi_lat <= cnt[15:8];
      if (!bus.read && is_io && off == 8'h04) cmp[7:0] <= bus.wdata;
      if (!bus.read && is_io && off == 8'h05) cmp[15:8] <= bus.wdata;
      if (cnt == cmp) flag <= 1'b1;
      else if (!bus.read && is_io && off == 8'h01 && bus.wdata[2]) flag <= 1'b0;
    end
  assign t_lo = cnt[7:0];
  assign t_hi = hi_lat;
  assign c_lo = cmp[7:0];
  assign c_hi = cmp[15:8];
`else
  assign flag = 1'b0;
  assign t_lo = 8'h00;
  assign t_hi = 8'h00;
  assign c_lo = 8'h00;
  assign c_hi = 8'h00;
`endif
  // read decode: RAM, I/O page, everything else floats high
  always_comb begin
    rd_val = 8'hFF;
    if (is_ram) rd_val = ram[bus.address[AW-1:0]];
    else if (is_io)
      case (off)
        8'h00:   rd_val = 8'h00;
        8'h01:   rd_val = status;
        8'h02:   rd_val = t_lo;
        8'h03:   rd_val = t_hi;
        8'h04:   rd_val = c_lo;
        8'h05:   rd_val = c_hi;
        default: rd_val = 8'hFF;
      endcase
  end
  // registered read data, held across write cycles
  always_ff @(posedge clk or negedge rst)
    if (!rst) rdata <= 8'h00;
    else if (bus.read) rdata <= rd_val;
  assign bus.rdata    = rdata;
  assign bus.tx_data  = fifo[rd_ptr];
  assign bus.tx_valid = !empty;
  assign bus.irq      = flag;
endmodule

// File: tb/tb_bus_responder.sv
// tb_bus_responder: directed + random bus traffic checked against a queue/array reference model
module tb_bus_responder;
  localparam int AW = 12;
`ifdef BUS_RESPONDER_TIMER_EN
  localparam bit TE = 1'b1;
`else
  localparam bit TE = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  bus_responder_if bus();
  bus_responder #(.AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int nchk = 0;
  int nerr = 0;
  logic [7:0]  q[$];
  logic [7:0]  mram[int];
  int          tcnt;
  logic [15:0] mcmp;
  logic [7:0]  mlat;
  logic        mflag;
  logic [7:0]  got;
  bit          seen;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    q.delete();
    tcnt  = 0;
    mcmp  = 16'hFFFF;
    mlat  = 8'h00;
    mflag = 1'b0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.read = 1'b1;
    bus.address = 16'h0000;
    bus.wdata = 8'h00;
    bus.tx_ready = 1'b0;
    #1;
    chk("reset_rdata", bus.rdata, 8'h00);
    chk("reset_tx_valid", bus.tx_valid, 1'b0);
    chk("reset_irq", bus.irq, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask
  task automatic cycle(input logic rd, input logic [15:0] a, input logic [7:0] wd, input logic rdy);
    logic [7:0]  exp;
    logic [15:0] pre;
    bit known, push, pop, set;
    @(negedge clk);
    bus.read = rd;
    bus.address = a;
    bus.wdata = wd;
    bus.tx_ready = rdy;
    pre = 16'(tcnt);
    known = 1'b1;
    exp = 8'hFF;
    if (int'(a) < (1 << AW)) begin
      known = mram.exists(int'(a));
      if (known) exp = mram[int'(a)];
    end else if (a[15:8] == 8'hFF)
      case (a[7:0])
        8'h00:   exp = 8'h00;
        8'h01:   exp = {5'd0, mflag, q.size() == 0, q.size() == 4};
        8'h02:   exp = TE ? pre[7:0] : 8'h00;
        8'h03:   exp = TE ? mlat : 8'h00;
        8'h04:   exp = TE ? mcmp[7:0] : 8'h00;
        8'h05:   exp = TE ? mcmp[15:8] : 8'h00;
        default: exp = 8'hFF;
      endcase
    pop  = q.size() > 0 && rdy;
    push = !rd && a == 16'hFF00 && q.size() < 4;
    @(posedge clk);
    #1;
    if (pop) void'(q.pop_front());
    if (push) q.push_back(wd);
    if (!rd && int'(a) < (1 << AW)) mram[int'(a)] = wd;
    if (TE) begin
      set = pre == mcmp;
      if (rd && a == 16'hFF02) mlat = pre[15:8];
      if (!rd && a == 16'hFF04) mcmp[7:0] = wd;
      if (!rd && a == 16'hFF05) mcmp[15:8] = wd;
      if (set) mflag = 1'b1;
      else if (!rd && a == 16'hFF01 && wd[2]) mflag = 1'b0;
      tcnt = (tcnt + 1) % 65536;
    end
    if (rd) got = bus.rdata;
    if (rd && known) chk($sformatf("rdata@%h", a), bus.rdata, exp);
    chk("tx_valid", bus.tx_valid, q.size() != 0);
    if (q.size() != 0) chk("tx_data", bus.tx_data, q[0]);
    chk("irq", bus.irq, mflag);
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [15:0] a;
    bus.read = 1'b1;
    bus.address = 16'h0000;
    bus.wdata = 8'h00;
    bus.tx_ready = 1'b0;
    model_reset();
    do_reset();
    cycle(1, 16'hFF01, 8'h00, 1'b0);
    chk("status_after_reset", got, 8'h02);
    cycle(1, 16'hFF04, 8'h00, 1'b0);
    chk("cmp_lo_reset", got, TE ? 8'hFF : 8'h00);
    cycle(1, 16'hFF05, 8'h00, 1'b0);
    chk("cmp_hi_reset", got, TE ? 8'hFF : 8'h00);
    cycle(0, 16'h0123, 8'h5A, 1'b0);
    cycle(0, 16'h0124, 8'hA5, 1'b0);
    cycle(1, 16'h0123, 8'h00, 1'b0);
    chk("ram_0123", got, 8'h5A);
    cycle(1, 16'h0124, 8'h00, 1'b0);
    chk("ram_0124", got, 8'hA5);
    cycle(1, 16'h8000, 8'h00, 1'b0);
    chk("unmapped_8000", got, 8'hFF);
    cycle(1, 16'h1000, 8'h00, 1'b0);
    chk("unmapped_1000", got, 8'hFF);
    cycle(0, 16'hFF06, 8'h12, 1'b0);
    cycle(1, 16'hFF06, 8'h00, 1'b0);
    chk("unmapped_ff06", got, 8'hFF);
    for (int i = 1; i <= 5; i++) cycle(0, 16'hFF00, 8'(i * 17), 1'b0);
    cycle(1, 16'hFF01, 8'h00, 1'b0);
    chk("status_full", got, 8'h01);
    cycle(1, 16'hFF00, 8'h00, 1'b0);
    chk("txdata_read", got, 8'h00);
    repeat (5) cycle(1, 16'h0123, 8'h00, 1'b1);
    chk("drained_valid", bus.tx_valid, 1'b0);
    cycle(0, 16'hFF00, 8'hA1, 1'b0);
    cycle(0, 16'hFF00, 8'hA2, 1'b0);
    cycle(0, 16'hFF00, 8'h77, 1'b1);
    cycle(0, 16'hFF00, 8'h88, 1'b0);
    cycle(0, 16'hFF00, 8'h99, 1'b0);
    cycle(1, 16'hFF01, 8'h00, 1'b0);
    chk("status_conc_full", got, 8'h01);
    cycle(0, 16'hFF00, 8'hAA, 1'b0);
    repeat (5) cycle(1, 16'h0123, 8'h00, 1'b1);
    cycle(0, 16'hFF00, 8'hC3, 1'b0);
    do_reset();
    cycle(1, 16'hFF01, 8'h00, 1'b0);
    chk("status_after_midreset", got, 8'h02);
`ifdef BUS_RESPONDER_TIMER_EN
    do_reset();
    cycle(0, 16'hFF04, 8'h10, 1'b0);
    cycle(0, 16'hFF05, 8'h00, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cycle(1, 16'h0123, 8'h00, 1'b0);
      seen = bus.irq;
    end
    chk("irq_set", seen, 1'b1);
    cycle(1, 16'hFF01, 8'h00, 1'b0);
    chk("status_flag", got, 8'h06);
    cycle(0, 16'hFF01, 8'h04, 1'b0);
    chk("irq_cleared", bus.irq, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 70000 && !seen; i++) begin
      cycle(1, 16'h0123, 8'h00, 1'b0);
      seen = bus.irq;
    end
    chk("irq_rearm", seen, 1'b1);
`else
    cycle(0, 16'hFF04, 8'h10, 1'b0);
    cycle(1, 16'hFF04, 8'h00, 1'b0);
    chk("notimer_cmp_lo", got, 8'h00);
    cycle(0, 16'hFF01, 8'hFF, 1'b0);
    cycle(1, 16'hFF01, 8'h00, 1'b0);
    chk("notimer_status", got, 8'h02);
`endif
    do_reset();
    repeat (255) cycle(1, 16'h0123, 8'h00, 1'b0);
    cycle(1, 16'hFF02, 8'h00, 1'b0);
    chk("latch_lo", got, TE ? 8'hFF : 8'h00);
    cycle(1, 16'hFF03, 8'h00, 1'b0);
    chk("latch_hi", got, 8'h00);
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 3))
        0:       a = 16'($urandom_range(0, 15));
        1:       a = 16'hFF00 | 16'($urandom_range(0, 7));
        2:       a = 16'h1000 | 16'($urandom_range(0, 255));
        default: a = 16'($urandom_range(16'h8000, 16'hFEFF));
      endcase
      cycle(1'($urandom_range(0, 1)), a, 8'($urandom), 1'($urandom_range(0, 1)));
    end
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
